// File: rtl/vga_timing_ctrl_if.sv
// Pixel request/return loop between the VGA timing controller and the image generator.
// The controller drives coordinates; the generator returns registered pixel data one clock later.
interface vga_timing_ctrl_if #(
    parameter int PIX_W = 16
);
    logic [9:0]       pix_x;
    logic [9:0]       pix_y;
    logic [PIX_W-1:0] pix_data;

    modport master (
        output pix_x,
        output pix_y,
        input  pix_data
    );

    modport slave (
        input  pix_x,
        input  pix_y,
        output pix_data
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 Hz VGA timing generator with a one-clock-ahead pixel request loop.
// Optional macro VGA_OUT_REG_EN registers hsync/vsync/rgb_valid/rgb/frame_start (one extra clock).
module vga_timing_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10,
    parameter int PIX_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    vga_timing_ctrl_if.master   pix_if,
    output logic                hsync,
    output logic                vsync,
    output logic                rgb_valid,
    output logic [PIX_W-1:0]    rgb,
    output logic                frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
    localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [9:0] H_REQ_LO = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_REQ_HI = 10'(H_SYNC + H_BACK + H_VALID - 2);
    localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BACK + V_VALID - 1);

    logic [9:0]       cnt_h_r;
    logic [9:0]       cnt_v_r;
    logic             hsync_s;
    logic             vsync_s;
    logic             v_win_s;
    logic             rgb_valid_s;
    logic             pix_req_s;
    logic [9:0]       pix_x_s;
    logic [9:0]       pix_y_s;
    logic [PIX_W-1:0] rgb_s;
    logic             frame_start_s;

    // Horizontal/vertical position counters; the line counter steps on the last pixel clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_h_r <= 10'd0;
            cnt_v_r <= 10'd0;
        end else if (cnt_h_r == H_LAST) begin
            cnt_h_r <= 10'd0;
            if (cnt_v_r == V_LAST) begin
                cnt_v_r <= 10'd0;
            end else begin
                cnt_v_r <= cnt_v_r + 10'd1;
            end
        end else begin
            cnt_h_r <= cnt_h_r + 10'd1;
        end
    end

    // Decode syncs, active window and the request window (one clock ahead of the active window).
    always_comb begin
        hsync_s     = (cnt_h_r < H_SYNC_C);
        vsync_s     = (cnt_v_r < V_SYNC_C);
        v_win_s     = (cnt_v_r >= V_ACT_LO) && (cnt_v_r <= V_ACT_HI);
        rgb_valid_s = (cnt_h_r >= H_ACT_LO) && (cnt_h_r <= H_ACT_HI) && v_win_s;
        pix_req_s   = (cnt_h_r >= H_REQ_LO) && (cnt_h_r <= H_REQ_HI) && v_win_s;
        if (pix_req_s) begin
            pix_x_s = cnt_h_r - H_REQ_LO;
            pix_y_s = cnt_v_r - V_ACT_LO;
        end else begin
            pix_x_s = 10'h3ff;
            pix_y_s = 10'h3ff;
        end
        if (rgb_valid_s) begin
            rgb_s = pix_if.pix_data;
        end else begin
            rgb_s = {PIX_W{1'b0}};
        end
        // Counters sit at 0,0 throughout reset; keep the strobe quiet until release.
        frame_start_s = (cnt_h_r == 10'd0) && (cnt_v_r == 10'd0) && !rst;
    end

    assign pix_if.pix_x = pix_x_s;
    assign pix_if.pix_y = pix_y_s;

`ifdef VGA_OUT_REG_EN
    logic             hsync_r;
    logic             vsync_r;
    logic             rgb_valid_r;
    logic [PIX_W-1:0] rgb_r;
    logic             frame_start_r;

    // Pin-side output stage, all outputs delayed together by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            rgb_valid_r   <= 1'b0;
            rgb_r         <= {PIX_W{1'b0}};
            frame_start_r <= 1'b0;
        end else begin
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            rgb_valid_r   <= rgb_valid_s;
            rgb_r         <= rgb_s;
            frame_start_r <= frame_start_s;
        end
    end

    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign rgb_valid   = rgb_valid_r;
    assign rgb         = rgb_r;
    assign frame_start = frame_start_r;
`else
    assign hsync       = hsync_s;
    assign vsync       = vsync_s;
    assign rgb_valid   = rgb_valid_s;
    assign rgb         = rgb_s;
    assign frame_start = frame_start_s;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: full-size instance for line/window checks, plus a
// shrunken-timing instance so whole-frame wrap and frame_start spacing fit in a short run.
module tb_vga_timing_ctrl;

`ifdef VGA_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    // Shrunken instance: H 4/3/8/2 (total 17, active from 7), V 1/2/3/1 (total 7, active from 3).
    localparam int SH_TOT = 17;
    localparam int SV_TOT = 7;
    localparam int S_FRAME = SH_TOT * SV_TOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync, vsync, rgb_valid, frame_start;
    logic [15:0] rgb;
    logic        s_hsync, s_vsync, s_rgb_valid, s_frame_start;
    logic [15:0] s_rgb;

    int n_vec = 0;
    int n_err = 0;

    always #20 clk = ~clk;

    vga_timing_ctrl_if #(.PIX_W(16)) pif ();
    vga_timing_ctrl_if #(.PIX_W(16)) sif ();

    vga_timing_ctrl dut (
        .clk(clk), .rst(rst), .pix_if(pif.master),
        .hsync(hsync), .vsync(vsync), .rgb_valid(rgb_valid), .rgb(rgb), .frame_start(frame_start)
    );

    vga_timing_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_VALID(3), .V_FRONT(1), .PIX_W(16)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_if(sif.master),
        .hsync(s_hsync), .vsync(s_vsync), .rgb_valid(s_rgb_valid), .rgb(s_rgb), .frame_start(s_frame_start)
    );

    function automatic logic [15:0] pat(input logic [9:0] x, input logic [9:0] y);
        return {x[4:0], y[5:0], x[9:5]};
    endfunction

    // Registered image generator: returns all-ones when nothing is requested.
    always @(posedge clk) begin
        pif.pix_data <= (pif.pix_x == 10'h3ff) ? 16'hffff : pat(pif.pix_x, pif.pix_y);
        sif.pix_data <= (sif.pix_x == 10'h3ff) ? 16'hffff : pat(sif.pix_x, sif.pix_y);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_rgb_valid"}, 32'(rgb_valid), 32'd0);
        check({tag, "_rgb"}, 32'(rgb), 32'd0);
        check({tag, "_pix_x"}, 32'(pif.pix_x), 32'h3ff);
        check({tag, "_pix_y"}, 32'(pif.pix_y), 32'h3ff);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        int fs_cnt, vs_cnt, hs_cnt, rv_cnt;
        int p, h, v, n_fs;
        int fs_pos[4];
        logic        exp_v;
        logic [15:0] exp_rgb;

        // ---------------- power-on reset ----------------
        rst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check_reset_vals("por");
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;

        // ---------------- run through line 37 of the full-size timing ----------------
        fs_cnt = 0; vs_cnt = 0; hs_cnt = 0; rv_cnt = 0;
        for (int k = 0; k < 37 * 800 + 400; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            p = k - LAT;
            if (k == LAT) check("fs_first", 32'(frame_start), 32'd1);
            if (k >= LAT) begin
                fs_cnt += int'(frame_start);
                vs_cnt += int'(vsync);
            end
            if (k >= 800 + LAT && k < 1600 + LAT) hs_cnt += int'(hsync);
            if (p == 95)   check("hs_95", 32'(hsync), 32'd1);
            if (p == 96)   check("hs_96", 32'(hsync), 32'd0);
            if (p == 799)  check("hs_799", 32'(hsync), 32'd0);
            if (p == 800)  check("hs_800", 32'(hsync), 32'd1);
            if (p == 1599) check("vs_1599", 32'(vsync), 32'd1);
            if (p == 1600) check("vs_1600", 32'(vsync), 32'd0);
            if (k == 400)  check("py_line0", 32'(pif.pix_y), 32'h3ff);
            if (k == 27600) begin
                check("px_line34", 32'(pif.pix_x), 32'h3ff);
                check("py_line34", 32'(pif.pix_y), 32'h3ff);
            end
            if (k == 28142) check("px_142", 32'(pif.pix_x), 32'h3ff);
            if (k == 28143) begin
                check("px_143", 32'(pif.pix_x), 32'd0);
                check("py_143", 32'(pif.pix_y), 32'd0);
            end
            if (k == 28782) check("px_782", 32'(pif.pix_x), 32'd639);
            if (k == 28783) begin
                check("px_783", 32'(pif.pix_x), 32'h3ff);
                check("py_783", 32'(pif.pix_y), 32'h3ff);
            end
            if (k == 29300) begin
                check("px_l36", 32'(pif.pix_x), 32'd357);
                check("py_l36", 32'(pif.pix_y), 32'd1);
            end
            // Lines 35 and 36: every rgb_valid/rgb sample against the expected window and pixel.
            if (p >= 28000 && p < 29600) begin
                h = p % 800;
                v = p / 800;
                exp_v = (h >= 144) && (h <= 783);
                exp_rgb = exp_v ? pat(10'(h - 144), 10'(v - 35)) : 16'h0000;
                if (v == 35) rv_cnt += int'(rgb_valid);
                check($sformatf("rgb_valid_%0d_%0d", v, h), 32'(rgb_valid), 32'(exp_v));
                check($sformatf("rgb_%0d_%0d", v, h), 32'(rgb), 32'(exp_rgb));
            end
        end
        check("fs_count", 32'(fs_cnt), 32'd1);
        check("vs_high", 32'(vs_cnt), 32'd1600);
        check("hs_high", 32'(hs_cnt), 32'd96);
        check("rv_line35", 32'(rv_cnt), 32'd640);

        // ---------------- mid-frame reset (line 37, column 400) ----------------
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("mid");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        fs_cnt = 0; rv_cnt = 0;
        for (int k = 0; k < 1700; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            p = k - LAT;
            if (k == LAT) check("rs_fs", 32'(frame_start), 32'd1);
            if (k >= LAT) fs_cnt += int'(frame_start);
            rv_cnt += int'(rgb_valid);
            if (p == 96)   check("rs_hs_96", 32'(hsync), 32'd0);
            if (p == 800)  check("rs_hs_800", 32'(hsync), 32'd1);
            if (p == 1599) check("rs_vs_1599", 32'(vsync), 32'd1);
            if (k == 143)  check("rs_px_143", 32'(pif.pix_x), 32'h3ff);
        end
        check("rs_fs_count", 32'(fs_cnt), 32'd1);
        check("rs_rv_count", 32'(rv_cnt), 32'd0);

        // ---------------- shrunken timing: frame wrap and frame_start spacing ----------------
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_fs = 0; vs_cnt = 0; hs_cnt = 0; rv_cnt = 0;
        for (int k = 0; k < 3 * S_FRAME; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            p = k - LAT;
            if (k >= LAT && s_frame_start) begin
                if (n_fs < 4) fs_pos[n_fs] = k;
                n_fs++;
            end
            if (p >= 0 && p < S_FRAME) begin
                hs_cnt += int'(s_hsync);
                vs_cnt += int'(s_vsync);
                rv_cnt += int'(s_rgb_valid);
                h = p % SH_TOT;
                v = p / SH_TOT;
                exp_v = (h >= 7) && (h <= 14) && (v >= 3) && (v <= 5);
                exp_rgb = exp_v ? pat(10'(h - 7), 10'(v - 3)) : 16'h0000;
                check($sformatf("s_rgb_%0d_%0d", v, h), 32'(s_rgb), 32'(exp_rgb));
            end
            if (k == 5 * SH_TOT + 13) begin
                check("s_px_last", 32'(sif.pix_x), 32'd7);
                check("s_py_last", 32'(sif.pix_y), 32'd2);
            end
            if (k == 6 * SH_TOT + 6) check("s_py_after", 32'(sif.pix_y), 32'h3ff);
            if (k == S_FRAME + 3 * SH_TOT + 6) check("s_px_wrap", 32'(sif.pix_x), 32'd0);
        end
        check("s_fs_count", 32'(n_fs), 32'd3);
        if (n_fs >= 3) begin
            check("s_fs_first", 32'(fs_pos[0]), 32'(LAT));
            check("s_fs_gap1", 32'(fs_pos[1] - fs_pos[0]), 32'(S_FRAME));
            check("s_fs_gap2", 32'(fs_pos[2] - fs_pos[1]), 32'(S_FRAME));
        end
        check("s_hs_high", 32'(hs_cnt), 32'd28);
        check("s_vs_high", 32'(vs_cnt), 32'd17);
        check("s_rv_high", 32'(rv_cnt), 32'd24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
